set_scheduler: RTL and testbench

Timed command scheduler for the testbench SET injection path. Queues SET commands (target index, value, delay) from scenario code, holds each for its programmed cycle delay, then issues it as a single-cycle write toward the SET output bank. It turns the immediate, one-shot set path into a deterministic, cycle-accurate stimulus sequence. It sits between the scenario command decoder and the SET output registers.

---
 rtl/set_sched_pkg.sv | 22 ++
 rtl/set_sched_fifo.sv | 70 +++++++
 rtl/set_scheduler.sv | 146 ++++++++++++++
 tb/tb_set_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/set_sched_pkg.sv
// Shared types for the SET command scheduler: FSM states, command layout
// and the issued-write counter width.
package set_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2
   } state_t;

   localparam int CMD_IDX_W    = 3;
   localparam int CMD_VALUE_W  = 32;
   localparam int CMD_DELAY_W  = 16;
   localparam int ISSUED_CNT_W = 16;

   typedef struct packed {
      logic [CMD_IDX_W-1:0]   idx;
      logic [CMD_VALUE_W-1:0] value;
      logic [CMD_DELAY_W-1:0] delay;
   } cmd_t;

endpackage

// File: rtl/set_sched_fifo.sv
// Synchronous command FIFO with flush. o_avail is registered from the next
// occupancy so it tracks o_level edge for edge.
module set_sched_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty,
   output logic             o_avail,
   output logic [LVL_W-1:0] o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             avail_q, avail_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({i_push, i_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
      avail_d = (level_d != LVL_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         avail_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         avail_q  <= avail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_wr_data;
   end

   assign o_rd_data = mem_q[rd_ptr_q];
   assign o_empty   = (level_q == '0);
   assign o_avail   = avail_q;
   assign o_level   = level_q;

endmodule

// File: rtl/set_scheduler.sv
// Timed SET command scheduler: queues {idx, value, delay}, waits the delay,
// then emits a one-cycle write strobe toward the SET output bank.
module set_scheduler
   import set_sched_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SET_SIZE    = 5,
   parameter int SET_WIDTH   = 32,
   parameter int DELAY_WIDTH = 16,
   parameter int IDX_W       = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic [IDX_W-1:0]          i_cmd_idx,
   input  logic [SET_WIDTH-1:0]      i_cmd_value,
   input  logic [DELAY_WIDTH-1:0]    i_cmd_delay,
   input  logic                      i_flush,
   output logic                      o_set_valid,
   output logic [IDX_W-1:0]          o_set_idx,
   output logic [SET_WIDTH-1:0]      o_set_value,
   output logic                      o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_level,
   output logic                      o_overflow,
   output logic                      o_bad_idx,
   output logic [ISSUED_CNT_W-1:0]   o_issued_cnt
);
   localparam int CMD_W = IDX_W + SET_WIDTH + DELAY_WIDTH;
   localparam logic [IDX_W:0] SET_SIZE_L = (IDX_W + 1)'(SET_SIZE);

   logic                   push, pop, fifo_empty, fifo_avail;
   logic [CMD_W-1:0]       head;
   logic [IDX_W-1:0]       head_idx;
   logic [SET_WIDTH-1:0]   head_value;
   logic [DELAY_WIDTH-1:0] head_delay;
   logic                   idx_ok;

   state_t                 state_q, state_d;
   logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d, set_idx_q, set_idx_d;
   logic [SET_WIDTH-1:0]   value_q, value_d, set_value_q, set_value_d;
   logic                   set_valid_q, set_valid_d;
   logic                   overflow_q, overflow_d, bad_q, bad_d;
   logic [ISSUED_CNT_W-1:0] issued_q, issued_d;

   set_sched_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (push),
      .i_pop     (pop),
      .i_flush   (i_flush),
      .i_wr_data ({i_cmd_idx, i_cmd_value, i_cmd_delay}),
      .o_rd_data (head),
      .o_empty   (fifo_empty),
      .o_avail   (fifo_avail),
      .o_level   (o_level)
   );

   assign o_cmd_ready = fifo_avail && !i_flush;
   assign push        = i_cmd_valid && o_cmd_ready;
   assign {head_idx, head_value, head_delay} = head;
   assign idx_ok      = ({1'b0, idx_q} < SET_SIZE_L);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      value_d     = value_q;
      set_valid_d = 1'b0;
      set_idx_d   = set_idx_q;
      set_value_d = set_value_q;
      pop         = 1'b0;
      overflow_d  = overflow_q | (i_cmd_valid & ~o_cmd_ready);
      bad_d       = bad_q | ((state_q == ISSUE) & ~idx_ok);
      issued_d    = set_valid_q ? issued_q + ISSUED_CNT_W'(1) : issued_q;

      if (i_flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            WAIT: begin
               if (cnt_q == '0) begin
                  state_d = ISSUE;
                  // Out-of-range targets still consume their slot but never strobe.
                  if (idx_ok) begin
                     set_valid_d = 1'b1;
                     set_idx_d   = idx_q;
                     set_value_d = value_q;
                  end
               end else begin
                  cnt_d = cnt_q - DELAY_WIDTH'(1);
               end
            end
            default: begin
               state_d = IDLE;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  idx_d   = head_idx;
                  value_d = head_value;
                  cnt_d   = head_delay;
                  state_d = WAIT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         value_q     <= '0;
         set_valid_q <= 1'b0;
         set_idx_q   <= '0;
         set_value_q <= '0;
         overflow_q  <= 1'b0;
         bad_q       <= 1'b0;
         issued_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         value_q     <= value_d;
         set_valid_q <= set_valid_d;
         set_idx_q   <= set_idx_d;
         set_value_q <= set_value_d;
         overflow_q  <= overflow_d;
         bad_q       <= bad_d;
         issued_q    <= issued_d;
      end
   end

   assign o_set_valid  = set_valid_q;
   assign o_set_idx    = set_idx_q;
   assign o_set_value  = set_value_q;
   assign o_busy       = (state_q != IDLE) || !fifo_empty;
   assign o_overflow   = overflow_q;
   assign o_bad_idx    = bad_q;
   assign o_issued_cnt = issued_q;

endmodule

// File: tb/tb_set_scheduler.sv
// Directed bench for set_scheduler: latency, spacing, overflow, bad index,
// flush and reset behaviour against hand-computed strobe cycles.
module tb_set_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [2:0]  i_cmd_idx;
   logic [31:0] i_cmd_value;
   logic [15:0] i_cmd_delay;
   logic        i_flush;
   logic        o_set_valid;
   logic [2:0]  o_set_idx;
   logic [31:0] o_set_value;
   logic        o_busy;
   logic [3:0]  o_level;
   logic        o_overflow;
   logic        o_bad_idx;
   logic [15:0] o_issued_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int strb_cyc[$];
   logic [2:0]  strb_idx[$];
   logic [31:0] strb_val[$];

   set_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_idx    (i_cmd_idx),
      .i_cmd_value  (i_cmd_value),
      .i_cmd_delay  (i_cmd_delay),
      .i_flush      (i_flush),
      .o_set_valid  (o_set_valid),
      .o_set_idx    (o_set_idx),
      .o_set_value  (o_set_value),
      .o_busy       (o_busy),
      .o_level      (o_level),
      .o_overflow   (o_overflow),
      .o_bad_idx    (o_bad_idx),
      .o_issued_cnt (o_issued_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log, sampled mid-cycle; cyc equals the edge that raised the strobe.
   always @(negedge clk) begin
      if (o_set_valid === 1'b1) begin
         strb_cyc.push_back(cyc);
         strb_idx.push_back(o_set_idx);
         strb_val.push_back(o_set_value);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] idx, input logic [31:0] val, input logic [15:0] dly,
                       output int e_n);
      i_cmd_valid = 1'b1;
      i_cmd_idx   = idx;
      i_cmd_value = val;
      i_cmd_delay = dly;
      step();
      e_n = cyc;
      i_cmd_valid = 1'b0;
   endtask

   task automatic clear_log();
      strb_cyc.delete();
      strb_idx.delete();
      strb_val.delete();
   endtask

   function automatic logic [63:0] cyc_at(input int i);
      return (i < strb_cyc.size()) ? 64'(strb_cyc[i]) : 64'hFFFF_FFFF;
   endfunction

   function automatic logic [63:0] idx_at(input int i);
      return (i < strb_idx.size()) ? 64'(strb_idx[i]) : 64'hFFFF_FFFF;
   endfunction

   function automatic logic [63:0] val_at(input int i);
      return (i < strb_val.size()) ? 64'(strb_val[i]) : 64'hFFFF_FFFF;
   endfunction

   initial begin
      int n, n2, n3, p;
      logic [15:0] exp_issued;

      rst_n = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_idx = '0;
      i_cmd_value = '0;
      i_cmd_delay = '0;
      i_flush = 1'b0;
      steps(3);
      check("rst_set_valid", 64'(o_set_valid), 64'd0);
      check("rst_set_value", 64'(o_set_value), 64'd0);
      check("rst_level", 64'(o_level), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_issued", 64'(o_issued_cnt), 64'd0);
      check("rst_ready", 64'(o_cmd_ready), 64'd0);
      rst_n = 1'b1;
      step();
      check("ready_after_rst", 64'(o_cmd_ready), 64'd1);
      exp_issued = 16'd0;

      // single command, delay 3 -> strobe 5 edges after acceptance
      clear_log();
      push(3'd2, 32'h1234, 16'd3, n);
      check("t1_level", 64'(o_level), 64'd1);
      steps(9);
      exp_issued = exp_issued + 16'd1;
      check("t1_count", 64'(strb_cyc.size()), 64'd1);
      check("t1_cyc", cyc_at(0), 64'(n + 5));
      check("t1_idx", idx_at(0), 64'd2);
      check("t1_val", val_at(0), 64'h1234);
      check("t1_issued", 64'(o_issued_cnt), 64'(exp_issued));
      check("t1_busy", 64'(o_busy), 64'd0);
      check("t1_hold_value", 64'(o_set_value), 64'h1234);

      // three back-to-back commands, delays 0,5,1
      clear_log();
      push(3'd0, 32'hA, 16'd0, n);
      push(3'd1, 32'hB, 16'd5, n2);
      push(3'd3, 32'hC, 16'd1, n3);
      steps(14);
      exp_issued = exp_issued + 16'd3;
      check("t2_count", 64'(strb_cyc.size()), 64'd3);
      check("t2_cyc0", cyc_at(0), 64'(n + 2));
      check("t2_cyc1", cyc_at(1), 64'(n + 9));
      check("t2_cyc2", cyc_at(2), 64'(n + 12));
      check("t2_val0", val_at(0), 64'hA);
      check("t2_val1", val_at(1), 64'hB);
      check("t2_val2", val_at(2), 64'hC);
      check("t2_idx2", idx_at(2), 64'd3);
      check("t2_issued", 64'(o_issued_cnt), 64'(exp_issued));

      // long-delay head holds the FSM in WAIT while the queue fills
      clear_log();
      push(3'd0, 32'h100, 16'd20, n);
      for (int k = 1; k <= 8; k++) push(3'd1, 32'h100 + 32'(k), 16'd0, p);
      check("t3_level_full", 64'(o_level), 64'd8);
      check("t3_ready_low", 64'(o_cmd_ready), 64'd0);
      check("t3_ovf_before", 64'(o_overflow), 64'd0);
      push(3'd2, 32'hDEAD, 16'd0, p);
      check("t3_overflow", 64'(o_overflow), 64'd1);
      check("t3_level_hold", 64'(o_level), 64'd8);
      steps(35);
      exp_issued = exp_issued + 16'd9;
      check("t3_count", 64'(strb_cyc.size()), 64'd9);
      check("t3_first_cyc", cyc_at(0), 64'(n + 22));
      check("t3_last_cyc", cyc_at(8), 64'(n + 38));
      check("t3_last_val", val_at(8), 64'h108);
      check("t3_issued", 64'(o_issued_cnt), 64'(exp_issued));
      check("t3_ready_back", 64'(o_cmd_ready), 64'd1);

      // out-of-range index spends its delay but never strobes
      clear_log();
      push(3'd7, 32'hBAD, 16'd2, n);
      push(3'd1, 32'h55, 16'd1, p);
      steps(10);
      exp_issued = exp_issued + 16'd1;
      check("t4_count", 64'(strb_cyc.size()), 64'd1);
      check("t4_cyc", cyc_at(0), 64'(n + 7));
      check("t4_idx", idx_at(0), 64'd1);
      check("t4_val", val_at(0), 64'h55);
      check("t4_bad_idx", 64'(o_bad_idx), 64'd1);
      check("t4_issued", 64'(o_issued_cnt), 64'(exp_issued));

      // flush mid-WAIT cancels everything queued and in flight
      clear_log();
      for (int k = 0; k < 4; k++) push(3'd2, 32'h200 + 32'(k), 16'd20, p);
      steps(5);
      i_flush = 1'b1;
      #1;
      check("t5_ready_in_flush", 64'(o_cmd_ready), 64'd0);
      step();
      i_flush = 1'b0;
      check("t5_level", 64'(o_level), 64'd0);
      check("t5_busy", 64'(o_busy), 64'd0);
      check("t5_sticky_ovf", 64'(o_overflow), 64'd1);
      steps(30);
      check("t5_no_strobe", 64'(strb_cyc.size()), 64'd0);
      push(3'd4, 32'h77, 16'd3, p);
      steps(7);
      exp_issued = exp_issued + 16'd1;
      check("t5_new_cyc", cyc_at(0), 64'(p + 5));
      check("t5_new_val", val_at(0), 64'h77);
      check("t5_issued", 64'(o_issued_cnt), 64'(exp_issued));

      // reset during WAIT drops the command
      clear_log();
      push(3'd0, 32'h99, 16'd10, n);
      steps(4);
      rst_n = 1'b0;
      step();
      check("t6_set_valid", 64'(o_set_valid), 64'd0);
      check("t6_set_idx", 64'(o_set_idx), 64'd0);
      check("t6_set_value", 64'(o_set_value), 64'd0);
      check("t6_overflow", 64'(o_overflow), 64'd0);
      check("t6_bad_idx", 64'(o_bad_idx), 64'd0);
      check("t6_issued", 64'(o_issued_cnt), 64'd0);
      check("t6_busy", 64'(o_busy), 64'd0);
      rst_n = 1'b1;
      steps(20);
      check("t6_no_strobe", 64'(strb_cyc.size()), 64'd0);
      check("t6_level", 64'(o_level), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
